// File: rtl/alu_exec_stage.sv
// alu_exec_stage: latches ALU operands, holds result/flags and pulses done. Optional ALU_OVF_EN adds ovf_out.
module alu_exec_stage #(
    parameter int WORD_LEN = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [WORD_LEN-1:0] a_in,
    input  logic [WORD_LEN-1:0] b_in,
    input  logic [1:0]          op_in,
    output logic [WORD_LEN-1:0] alu_in1,
    output logic [WORD_LEN-1:0] alu_in2,
    output logic [1:0]          alu_op,
    input  logic [WORD_LEN-1:0] alu_result,
    input  logic                alu_zer,
    input  logic                alu_neg,
    output logic [WORD_LEN-1:0] result_out,
    output logic                zer_out,
    output logic                neg_out,
`ifdef ALU_OVF_EN
    output logic                ovf_out,
`endif
    output logic                busy,
    output logic                done
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    state_t state, state_nxt;
    logic load;
    always_comb begin
        load = start && state != EXEC;
        state_nxt = state == EXEC ? DONE : load ? EXEC : IDLE;
        busy = state == EXEC;
        done = state == DONE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            alu_in1    <= '0;
            alu_in2    <= '0;
            alu_op     <= '0;
            result_out <= '0;
            zer_out    <= 1'b0;
            neg_out    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load) begin
                alu_in1 <= a_in;
                alu_in2 <= b_in;
                alu_op  <= op_in;
            end
            if (busy) begin
                result_out <= alu_result;
                zer_out    <= alu_zer;
                neg_out    <= alu_neg;
            end
        end
    end
`ifdef ALU_OVF_EN
    localparam int M = WORD_LEN - 1;
    logic ovf;
    // signed overflow judged from the latched operands and the ALU's result sign
    always_comb
        ovf = alu_op == 2'd0 ? (alu_in1[M] == alu_in2[M]) && (alu_result[M] != alu_in1[M]) :
              alu_op == 2'd1 ? (alu_in1[M] != alu_in2[M]) && (alu_result[M] != alu_in1[M]) : 1'b0;
    always_ff @(posedge clk) begin
        if (rst) ovf_out <= 1'b0;
        else if (busy) ovf_out <= ovf;
    end
`endif
endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage: directed plus randomized checks of alu_exec_stage against a timeline model.
module tb_alu_exec_stage;
    localparam int W = 32;
    logic clk = 1'b0;
    logic rst, start;
    logic [W-1:0] a_in, b_in, alu_in1, alu_in2, alu_result, result_out;
    logic [1:0] op_in, alu_op;
    logic alu_zer, alu_neg, zer_out, neg_out, busy, done;
`ifdef ALU_OVF_EN
    logic ovf_out;
`endif
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_exec_stage #(.WORD_LEN(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in), .op_in(op_in),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op),
        .alu_result(alu_result), .alu_zer(alu_zer), .alu_neg(alu_neg),
        .result_out(result_out), .zer_out(zer_out), .neg_out(neg_out),
`ifdef ALU_OVF_EN
        .ovf_out(ovf_out),
`endif
        .busy(busy), .done(done)
    );

    function automatic logic [W-1:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
        case (op)
            2'd0: return a + b;
            2'd1: return a - b;
            2'd2: return a & b;
            default: return a | b;
        endcase
    endfunction

    // overflow from exact signed arithmetic in one extra bit
    function automatic logic ovf_f(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
        logic signed [W:0] s;
        if (op == 2'd0) s = $signed({a[W-1], a}) + $signed({b[W-1], b});
        else if (op == 2'd1) s = $signed({a[W-1], a}) - $signed({b[W-1], b});
        else return 1'b0;
        return s[W] != s[W-1];
    endfunction

    assign alu_result = alu_f(alu_in1, alu_in2, alu_op);
    assign alu_zer = alu_result == '0;
    assign alu_neg = alu_result[W-1];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // model: k counts edges; t_acc is the edge that accepted the current op
    int k = 0;
    int t_acc = -10;
    logic [W-1:0] m_a = '0, m_b = '0, m_res = '0;
    logic [1:0] m_op = '0;
    logic m_zer = 1'b0, m_neg = 1'b0, m_ovf = 1'b0;

    always @(posedge clk) begin
        k++;
        if (rst) begin
            t_acc = -10;
            m_a = '0; m_b = '0; m_op = '0; m_res = '0;
            m_zer = 1'b0; m_neg = 1'b0; m_ovf = 1'b0;
        end else if (k == t_acc + 1) begin
            m_res = alu_f(m_a, m_b, m_op);
            m_zer = m_res == '0;
            m_neg = m_res[W-1];
            m_ovf = ovf_f(m_a, m_b, m_op);
        end else if (start) begin
            t_acc = k;
            m_a = a_in; m_b = b_in; m_op = op_in;
        end
    end

    always @(negedge clk) begin
        if (k > 0) begin
            chk("m_busy", busy, k == t_acc);
            chk("m_done", done, k == t_acc + 1);
            chk("m_in1", alu_in1, m_a);
            chk("m_in2", alu_in2, m_b);
            chk("m_op", alu_op, m_op);
            chk("m_res", result_out, m_res);
            chk("m_zer", zer_out, m_zer);
            chk("m_neg", neg_out, m_neg);
`ifdef ALU_OVF_EN
            chk("m_ovf", ovf_out, m_ovf);
`endif
        end
    end

    // issue an op from IDLE or DONE; returns in the DONE cycle
    task automatic go(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
        start = 1'b1; a_in = a; b_in = b; op_in = op;
        @(negedge clk);
        chk("go_busy", busy, 1);
        start = 1'b0; a_in = $urandom; b_in = $urandom; op_in = 2'($urandom);
        @(negedge clk);
        chk("go_done", done, 1);
        chk("go_in1", alu_in1, a);
        chk("go_in2", alu_in2, b);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0; op_in = '0;
        repeat (2) @(negedge clk);
        chk("rst_res", result_out, 0);
        chk("rst_zer", zer_out, 0);
        chk("rst_neg", neg_out, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_res", result_out, 0);
        chk("idle_busy", busy, 0);
        go(5, 7, 0);
        chk("add_res", result_out, 12);
        chk("add_zer", zer_out, 0);
        chk("add_neg", neg_out, 0);
        @(negedge clk);
        go(9, 9, 1);
        chk("sub0_res", result_out, 0);
        chk("sub0_zer", zer_out, 1);
        @(negedge clk);
        go(3, 4, 1);
        chk("subn_res", result_out, 32'hFFFF_FFFF);
        chk("subn_neg", neg_out, 1);
        go(32'hF0, 32'h0F, 3);
        chk("b2b_res", result_out, 32'hFF);
        @(negedge clk);
        start = 1'b1; a_in = 10; b_in = 3; op_in = 1;
        @(negedge clk);
        start = 1'b1; a_in = 77; b_in = 1; op_in = 0;
        @(negedge clk);
        start = 1'b0;
        chk("ign_in1", alu_in1, 10);
        chk("ign_res", result_out, 7);
        @(negedge clk);
        chk("ign_done", done, 0);
        chk("ign_busy", busy, 0);
        start = 1'b1; a_in = 32'hFF; b_in = 32'h0F; op_in = 2;
        @(negedge clk);
        start = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("abort_done", done, 0);
        chk("abort_res", result_out, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_idle_busy", busy, 0);
        chk("abort_idle_done", done, 0);
`ifdef ALU_OVF_EN
        go(32'h7FFF_FFFF, 1, 0);
        chk("ovf_add", ovf_out, 1);
        chk("ovf_add_neg", neg_out, 1);
        go(32'h8000_0000, 1, 1);
        chk("ovf_sub", ovf_out, 1);
        go(32'h8000_0000, 32'h8000_0000, 2);
        chk("ovf_and", ovf_out, 0);
`endif
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom % 64) == 0;
            start = $urandom % 2;
            case ($urandom % 4)
                0: a_in = 32'h7FFF_FFFF;
                1: a_in = 32'h8000_0000;
                default: a_in = $urandom;
            endcase
            b_in = ($urandom % 4 == 0) ? a_in : $urandom;
            op_in = 2'($urandom);
            @(negedge clk);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
